// File: rtl/aes_dec_pkg.sv
// Shared definitions for the AES decryption round controller: state encoding,
// round counts per key size and key_len encodings.
package aes_dec_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ARK0,
        S_ISR,
        S_ISB,
        S_ARK,
        S_IMC,
        S_ISR_F,
        S_ISB_F,
        S_ARK_F,
        S_DONE
    } state_t;

    localparam logic [3:0] NR_128 = 4'd10;
    localparam logic [3:0] NR_192 = 4'd12;
    localparam logic [3:0] NR_256 = 4'd14;

    localparam logic [1:0] KEY_128 = 2'd0;
    localparam logic [1:0] KEY_192 = 2'd1;
    localparam logic [1:0] KEY_256 = 2'd2;
    localparam logic [1:0] KEY_BAD = 2'd3;

    // Round count for a key size; 0 marks the illegal encoding.
    function automatic logic [3:0] nr_of(input logic [1:0] kl);
        case (kl)
            KEY_128: return NR_128;
            KEY_192: return NR_192;
            KEY_256: return NR_256;
            default: return 4'd0;
        endcase
    endfunction

    // Round decrement that holds at zero instead of wrapping.
    function automatic logic [3:0] sat_dec(input logic [3:0] r);
        return (r != 4'd0) ? r - 4'd1 : 4'd0;
    endfunction

endpackage

// File: rtl/aes_dec_round_ctrl.sv
// Sequences AddRoundKey / InvShiftRows / InvSubBytes / InvMixColumns for one
// AES block decryption, launching exactly one sub-block at a time.
module aes_dec_round_ctrl
    import aes_dec_pkg::*;
#(
    parameter int NR_MAX = 14
) (
    input  logic       ap_clk,
    input  logic       ap_rst_n,
    input  logic       ap_start,
    output logic       ap_done,
    output logic       ap_idle,
    output logic       ap_ready,
    input  logic [1:0] key_len,
    output logic       ark_start,
    input  logic       ark_done,
    output logic [4:0] ark_n,
    output logic       isr_start,
    input  logic       isr_done,
    output logic       isb_start,
    input  logic       isb_done,
    output logic       imc_start,
    input  logic       imc_done,
    output logic [3:0] cur_round,
    output logic       err
);

    state_t     state_reg, state_next;
    logic [3:0] round_reg, round_next;
    logic       err_reg, err_next;
    logic [3:0] nr_sel;
    logic       key_bad;

    assign nr_sel = nr_of(key_len);
    // Key sizes whose round count exceeds the build limit are treated as illegal.
    assign key_bad = (key_len == KEY_BAD) || (int'(nr_sel) > NR_MAX);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_reg <= S_IDLE;
            round_reg <= 4'd0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            round_reg <= round_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        round_next = round_reg;
        err_next   = err_reg;
        case (state_reg)
            S_IDLE: begin
                if (ap_start) begin
                    if (key_bad) begin
                        err_next   = 1'b1;
                        state_next = S_DONE;
                    end else begin
                        err_next   = 1'b0;
                        round_next = nr_sel;
                        state_next = S_ARK0;
                    end
                end
            end
            S_ARK0: begin
                if (ark_done) begin
                    round_next = sat_dec(round_reg);
                    state_next = (round_reg >= 4'd2) ? S_ISR : S_ISR_F;
                end
            end
            S_ISR:   if (isr_done) state_next = S_ISB;
            S_ISB:   if (isb_done) state_next = S_ARK;
            S_ARK:   if (ark_done) state_next = S_IMC;
            S_IMC: begin
                if (imc_done) begin
                    round_next = sat_dec(round_reg);
                    state_next = (round_reg >= 4'd2) ? S_ISR : S_ISR_F;
                end
            end
            S_ISR_F: if (isr_done) state_next = S_ISB_F;
            S_ISB_F: if (isb_done) state_next = S_ARK_F;
            S_ARK_F: if (ark_done) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        ark_start = 1'b0;
        isr_start = 1'b0;
        isb_start = 1'b0;
        imc_start = 1'b0;
        ap_done   = 1'b0;
        ap_ready  = 1'b0;
        ap_idle   = 1'b0;
        ark_n     = 5'd0;
        case (state_reg)
            S_IDLE: ap_idle = 1'b1;
            S_ARK0, S_ARK: begin
                ark_start = 1'b1;
                ark_n     = {1'b0, round_reg};
            end
            S_ARK_F:          ark_start = 1'b1;
            S_ISR, S_ISR_F:   isr_start = 1'b1;
            S_ISB, S_ISB_F:   isb_start = 1'b1;
            S_IMC:            imc_start = 1'b1;
            S_DONE: begin
                ap_done  = 1'b1;
                ap_ready = 1'b1;
            end
            default: ;
        endcase
    end

    assign cur_round = round_reg;
    assign err       = err_reg;

endmodule
